// File: rtl/iob_master_ctrl.sv
// -----------------------------------------------------------------------------
// iob_master_ctrl
//   Master side of the IOB FIFO handshake. Takes one queued request at a time
//   from the CPU-side slave FIFO and runs it as a 68000-style asynchronous bus
//   cycle on the slow IOB:
//     IDLE -> ADDR -> AS -> DS -> WAIT -> LATCH -> RECOVER -> IDLE
//   All bus-facing outputs are registered so the strobes are glitch-free, and
//   they are decoded from the next state so that they change on the same edge
//   as the state register.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   IOREQ                request pending from the slave FIFO (level)
//   IORW0, IOL0, IOU0    direction (1=read) and byte strobes, sampled at accept
//   IOACT                request accepted and in flight
//   ALE0                 one-cycle pulse: latch FIFO level-0 addr/data onto IOB
//   IOBERR               one-cycle pulse at cycle end on bus error or timeout
//   nAS_IOB, nLDS_IOB,
//   nUDS_IOB, nWE_IOB    IOB address strobe, data strobes, R/W (0=write)
//   nDoutOE              drive write data onto the IOB (low active)
//   nDinLE               read data latch enable (low active)
//   nDTACK_IOB, nBERR_IOB asynchronous IOB acknowledge / bus error inputs
// -----------------------------------------------------------------------------
module iob_master_ctrl #(
   parameter int STATE_CYC = 2,    // CLK cycles per half-state, >=1
   parameter int DTACK_TO  = 255,  // WAIT cycles before timeout, >=2
   parameter int SYNC      = 2     // synchronizer depth, >=2
) (
   input  logic CLK,
   input  logic nRST,
   input  logic IOREQ,
   input  logic IORW0,
   input  logic IOL0,
   input  logic IOU0,
   output logic IOACT,
   output logic ALE0,
   output logic IOBERR,
   output logic nAS_IOB,
   output logic nLDS_IOB,
   output logic nUDS_IOB,
   output logic nWE_IOB,
   output logic nDoutOE,
   output logic nDinLE,
   input  logic nDTACK_IOB,
   input  logic nBERR_IOB
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ADDR    = 3'd1;
   localparam logic [2:0] ST_AS      = 3'd2;
   localparam logic [2:0] ST_DS      = 3'd3;
   localparam logic [2:0] ST_WAIT    = 3'd4;
   localparam logic [2:0] ST_LATCH   = 3'd5;
   localparam logic [2:0] ST_RECOVER = 3'd6;

   localparam logic [7:0] SC_LAST = 8'(STATE_CYC - 1);
   localparam logic [7:0] TO_LAST = 8'(DTACK_TO - 1);

   logic [2:0]      state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            armed_q, armed_d;
   logic            rw_q, rw_d, l_q, l_d, u_q, u_d;
   logic            dtk_seen_q, dtk_seen_d;
   logic            err_q, err_d;
   logic [SYNC-1:0] dtack_sync, berr_sync;

   logic dtack_s, berr_s, sc_done;
   logic act_d, ale_d, as_d, strb_d, we_d, dinle_d, berr_pulse_d;

   // Synchronizer shift registers; idle (negated) value is 1.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         dtack_sync <= '1;
         berr_sync  <= '1;
      end else begin
         dtack_sync <= {dtack_sync[SYNC-2:0], nDTACK_IOB};
         berr_sync  <= {berr_sync[SYNC-2:0], nBERR_IOB};
      end
   end

   assign dtack_s = ~dtack_sync[SYNC-1];   // 1 = acknowledge asserted
   assign berr_s  = ~berr_sync[SYNC-1];    // 1 = bus error asserted
   assign sc_done = (cnt_q == SC_LAST);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 8'd1;
      rw_d       = rw_q;
      l_d        = l_q;
      u_d        = u_q;
      dtk_seen_d = dtk_seen_q;
      err_d      = err_q;

      // A request held high runs once; IOREQ must drop for a cycle to re-arm.
      armed_d = armed_q;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (IOREQ && armed_q) begin
               state_d = ST_ADDR;
               armed_d = 1'b0;
               rw_d    = IORW0;
               l_d     = IOL0;
               u_d     = IOU0;
            end
         end
         ST_ADDR: begin
            state_d    = ST_AS;
            cnt_d      = '0;
            dtk_seen_d = 1'b0;
            err_d      = 1'b0;
         end
         ST_AS: if (sc_done) begin
            state_d = ST_DS;
            cnt_d   = '0;
         end
         ST_DS: if (sc_done) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            // DTACK wins for the read latch; BERR or timeout still flags error.
            if (dtack_s || berr_s || cnt_q == TO_LAST) begin
               state_d    = ST_LATCH;
               cnt_d      = '0;
               dtk_seen_d = dtack_s;
               err_d      = berr_s | ~dtack_s;
            end
         end
         ST_LATCH: if (sc_done) begin
            state_d = ST_RECOVER;
            cnt_d   = '0;
         end
         ST_RECOVER: begin
            // Hold the counter once the minimum is met; then wait for the
            // slave to release DTACK before the next cycle may start.
            if (sc_done) begin
               cnt_d = cnt_q;
               if (!dtack_s) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (!IOREQ) armed_d = 1'b1;
   end

   // Output decode from the next state, registered below.
   always_comb begin
      act_d   = (state_d == ST_ADDR) || (state_d == ST_AS) || (state_d == ST_DS) ||
                (state_d == ST_WAIT) || (state_d == ST_LATCH);
      ale_d   = (state_d == ST_ADDR);
      as_d    = (state_d == ST_AS) || (state_d == ST_DS) ||
                (state_d == ST_WAIT) || (state_d == ST_LATCH);
      // Reads assert data strobes with AS; writes wait one state for data setup.
      strb_d  = (state_d == ST_DS) || (state_d == ST_WAIT) || (state_d == ST_LATCH) ||
                ((state_d == ST_AS) && rw_d);
      we_d    = !rw_d && (as_d || (state_d == ST_RECOVER));
      dinle_d = (state_d == ST_LATCH) && rw_d && dtk_seen_d;
      berr_pulse_d = (state_d == ST_RECOVER) && (state_q == ST_LATCH) && err_d;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         armed_q    <= 1'b1;
         rw_q       <= 1'b0;
         l_q        <= 1'b0;
         u_q        <= 1'b0;
         dtk_seen_q <= 1'b0;
         err_q      <= 1'b0;
         IOACT      <= 1'b0;
         ALE0       <= 1'b0;
         IOBERR     <= 1'b0;
         nAS_IOB    <= 1'b1;
         nLDS_IOB   <= 1'b1;
         nUDS_IOB   <= 1'b1;
         nWE_IOB    <= 1'b1;
         nDoutOE    <= 1'b1;
         nDinLE     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         armed_q    <= armed_d;
         rw_q       <= rw_d;
         l_q        <= l_d;
         u_q        <= u_d;
         dtk_seen_q <= dtk_seen_d;
         err_q      <= err_d;
         IOACT      <= act_d;
         ALE0       <= ale_d;
         IOBERR     <= berr_pulse_d;
         nAS_IOB    <= ~as_d;
         nLDS_IOB   <= ~(strb_d & l_d);
         nUDS_IOB   <= ~(strb_d & u_d);
         nWE_IOB    <= ~we_d;
         nDoutOE    <= ~we_d;
         nDinLE     <= ~dinle_d;
      end
   end

endmodule
